// File: rtl/thread_fetch_sequencer.sv
// Per-thread PC sequencer: resolves execute-stage branches, issues one round-robin fetch per cycle.
// Optional taken-branch counter is built when BRANCH_COUNT_EN is defined.
module thread_fetch_sequencer #(
    parameter int DATAPATH_WIDTH  = 64,
    parameter int INST_ADDR_WIDTH = 9,
    parameter int THREAD_BITS     = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic                         ex_valid,
    input  logic [THREAD_BITS-1:0]       ex_thread_id,
    input  logic [INST_ADDR_WIDTH-1:0]   ex_pc,
    input  logic [DATAPATH_WIDTH-1:0]    R1_data_in,
    input  logic [DATAPATH_WIDTH-1:0]    R2_data_in,
    input  logic                         beq_in,
    input  logic                         bneq_in,
    input  logic [INST_ADDR_WIDTH-1:0]   branch_offset_in,
    input  logic                         start_valid,
    input  logic [THREAD_BITS-1:0]       start_id,
    input  logic [INST_ADDR_WIDTH-1:0]   start_pc,
    input  logic                         stop_valid,
    input  logic [THREAD_BITS-1:0]       stop_id,
    output logic                         fetch_valid,
    output logic [INST_ADDR_WIDTH-1:0]   fetch_pc,
    output logic [THREAD_BITS-1:0]       fetch_thread_id,
    output logic                         flush_valid,
    output logic [THREAD_BITS-1:0]       flush_thread_id,
`ifdef BRANCH_COUNT_EN
    output logic [31:0]                  branch_count,
`endif
    output logic [(1<<THREAD_BITS)-1:0]  thread_running
);

    localparam int NT = 1 << THREAD_BITS;

    logic [NT-1:0]              running_r;
    logic [NT-1:0]              running_next_s;
    logic [INST_ADDR_WIDTH-1:0] pc_r      [NT];
    logic [INST_ADDR_WIDTH-1:0] pc_next_s [NT];
    logic [THREAD_BITS-1:0]     last_tid_r;

    logic                       taken_s;
    logic [INST_ADDR_WIDTH-1:0] target_s;
    logic                       cand_found_s;
    logic [THREAD_BITS-1:0]     cand_s;
    logic [THREAD_BITS-1:0]     scan_idx_s;
    logic                       bypass_s;
    logic [INST_ADDR_WIDTH-1:0] fetch_addr_s;
    logic                       start_ok_s;

    assign thread_running = running_r;

    // Branch resolution against the pre-cycle RUN state
    always_comb begin
        taken_s  = 1'b0;
        target_s = ex_pc + branch_offset_in;
        if (en && ex_valid && running_r[ex_thread_id]) begin
            taken_s = (beq_in  && (R1_data_in == R2_data_in)) ||
                      (bneq_in && (R1_data_in != R2_data_in));
        end else begin
            taken_s = 1'b0;
        end
    end

    // Round-robin candidate: scanning from the far end lets the nearest RUN thread after last_tid win
    always_comb begin
        cand_found_s = 1'b0;
        cand_s       = '0;
        scan_idx_s   = '0;
        for (int k = NT; k >= 1; k--) begin
            scan_idx_s = last_tid_r + THREAD_BITS'(k);
            if (running_r[scan_idx_s]) begin
                cand_found_s = 1'b1;
                cand_s       = scan_idx_s;
            end else begin
                cand_found_s = cand_found_s;
            end
        end
        bypass_s     = taken_s && (cand_s == ex_thread_id);
        fetch_addr_s = bypass_s ? target_s : pc_r[cand_s];
    end

    // Next PC / RUN state: redirect, fetch increment, then start and stop (stop wins)
    always_comb begin
        running_next_s = running_r;
        for (int t = 0; t < NT; t++) begin
            pc_next_s[t] = pc_r[t];
        end
        if (taken_s) begin
            pc_next_s[ex_thread_id] = target_s;
        end else begin
            running_next_s = running_next_s;
        end
        if (en && cand_found_s) begin
            pc_next_s[cand_s] = fetch_addr_s + INST_ADDR_WIDTH'(1'b1);
        end else begin
            running_next_s = running_next_s;
        end
        start_ok_s = start_valid && !running_r[start_id] &&
                     !(stop_valid && (stop_id == start_id));
        if (start_ok_s) begin
            running_next_s[start_id] = 1'b1;
            pc_next_s[start_id]      = start_pc;
        end else begin
            running_next_s = running_next_s;
        end
        if (stop_valid) begin
            running_next_s[stop_id] = 1'b0;
        end else begin
            running_next_s = running_next_s;
        end
    end

    // State and registered outputs; fetch path and pointer freeze while en is low
    always_ff @(posedge clk) begin
        if (reset) begin
            running_r       <= '0;
            last_tid_r      <= THREAD_BITS'(NT - 1);
            fetch_valid     <= 1'b0;
            fetch_pc        <= '0;
            fetch_thread_id <= '0;
            flush_valid     <= 1'b0;
            flush_thread_id <= '0;
            for (int t = 0; t < NT; t++) begin
                pc_r[t] <= '0;
            end
`ifdef BRANCH_COUNT_EN
            branch_count    <= 32'd0;
`endif
        end else begin
            running_r <= running_next_s;
            for (int t = 0; t < NT; t++) begin
                pc_r[t] <= pc_next_s[t];
            end
            if (en) begin
                if (cand_found_s) begin
                    fetch_valid     <= 1'b1;
                    fetch_pc        <= fetch_addr_s;
                    fetch_thread_id <= cand_s;
                    last_tid_r      <= cand_s;
                end else begin
                    fetch_valid     <= 1'b0;
                end
            end
            flush_valid <= taken_s;
            if (taken_s) begin
                flush_thread_id <= ex_thread_id;
`ifdef BRANCH_COUNT_EN
                branch_count    <= branch_count + 32'd1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_thread_fetch_sequencer.sv
// Scoreboard bench for thread_fetch_sequencer: an array-based reference model predicts each
// cycle's outputs into a queue; a monitor pops and compares after every clock edge.
module tb_thread_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset, en, ex_valid, beq_in, bneq_in;
    logic [1:0]  ex_thread_id, start_id, stop_id;
    logic [8:0]  ex_pc, branch_offset_in, start_pc;
    logic [63:0] R1_data_in, R2_data_in;
    logic        start_valid, stop_valid;
    logic        fetch_valid, flush_valid;
    logic [8:0]  fetch_pc;
    logic [1:0]  fetch_thread_id, flush_thread_id;
    logic [3:0]  thread_running;
    logic [31:0] branch_count_w;
`ifdef BRANCH_COUNT_EN
    logic [31:0] branch_count;
    assign branch_count_w = branch_count;
`else
    assign branch_count_w = 32'd0;
`endif

    thread_fetch_sequencer dut (
        .clk(clk), .reset(reset), .en(en), .ex_valid(ex_valid),
        .ex_thread_id(ex_thread_id), .ex_pc(ex_pc),
        .R1_data_in(R1_data_in), .R2_data_in(R2_data_in),
        .beq_in(beq_in), .bneq_in(bneq_in), .branch_offset_in(branch_offset_in),
        .start_valid(start_valid), .start_id(start_id), .start_pc(start_pc),
        .stop_valid(stop_valid), .stop_id(stop_id),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_thread_id(fetch_thread_id),
        .flush_valid(flush_valid), .flush_thread_id(flush_thread_id),
`ifdef BRANCH_COUNT_EN
        .branch_count(branch_count),
`endif
        .thread_running(thread_running)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        fv;
        logic [8:0]  fpc;
        logic [1:0]  ftid;
        logic        flv;
        logic [1:0]  flid;
        logic [3:0]  run;
        logic [31:0] bc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // reference model state
    bit [3:0] m_run;
    int       m_pc[4];
    int       m_last;
    exp_t     e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit       taken, found;
        int       tgt, c;
        bit [3:0] nr;
        if (reset) begin
            m_run = 4'd0;
            for (int t = 0; t < 4; t++) m_pc[t] = 0;
            m_last = 3;
            e = '0;
        end else begin
            taken = en && ex_valid && m_run[ex_thread_id] &&
                    ((beq_in && R1_data_in == R2_data_in) || (bneq_in && R1_data_in != R2_data_in));
            tgt = (int'(ex_pc) + int'(branch_offset_in)) % 512;
            if (taken) m_pc[ex_thread_id] = tgt;
            if (en) begin
                found = 0;
                c = 0;
                for (int k = 1; k <= 4; k++) begin
                    if (!found && m_run[(m_last + k) % 4]) begin
                        found = 1;
                        c = (m_last + k) % 4;
                    end
                end
                if (found) begin
                    e.fv   = 1'b1;
                    e.fpc  = 9'(m_pc[c]);
                    e.ftid = 2'(c);
                    m_pc[c] = (m_pc[c] + 1) % 512;
                    m_last = c;
                end else begin
                    e.fv = 1'b0;
                end
            end
            e.flv = taken;
            if (taken) begin
                e.flid = ex_thread_id;
`ifdef BRANCH_COUNT_EN
                e.bc = e.bc + 32'd1;
`endif
            end
            nr = m_run;
            if (start_valid && !m_run[start_id] && !(stop_valid && stop_id == start_id)) begin
                nr[start_id] = 1'b1;
                m_pc[start_id] = int'(start_pc);
            end
            if (stop_valid) nr[stop_id] = 1'b0;
            m_run = nr;
        end
        e.run = m_run;
    endtask

    // inputs are already applied; predict, queue, and advance one cycle
    task automatic tick();
        model_step();
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle();
        reset = 1'b0; en = 1'b1; ex_valid = 1'b0; beq_in = 1'b0; bneq_in = 1'b0;
        ex_thread_id = 2'd0; ex_pc = 9'd0; branch_offset_in = 9'd0;
        R1_data_in = 64'd0; R2_data_in = 64'd0;
        start_valid = 1'b0; start_id = 2'd0; start_pc = 9'd0;
        stop_valid = 1'b0; stop_id = 2'd0;
    endtask

    task automatic branch(input logic [1:0] tid, input logic [8:0] pc, input logic [8:0] off,
                          input logic [63:0] a, input logic [63:0] b, input logic bq, input logic bn);
        ex_valid = 1'b1; ex_thread_id = tid; ex_pc = pc; branch_offset_in = off;
        R1_data_in = a; R2_data_in = b; beq_in = bq; bneq_in = bn;
    endtask

    task automatic start(input logic [1:0] id, input logic [8:0] pc);
        start_valid = 1'b1; start_id = id; start_pc = pc;
    endtask

    // monitor: compare every presented output cycle against the predicted snapshot
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (q.size() > 0) begin
            x = q.pop_front();
            chk("fetch_valid", 32'(fetch_valid), 32'(x.fv));
            chk("fetch_pc", 32'(fetch_pc), 32'(x.fpc));
            chk("fetch_thread_id", 32'(fetch_thread_id), 32'(x.ftid));
            chk("flush_valid", 32'(flush_valid), 32'(x.flv));
            if (x.flv) chk("flush_thread_id", 32'(flush_thread_id), 32'(x.flid));
            chk("thread_running", 32'(thread_running), 32'(x.run));
`ifdef BRANCH_COUNT_EN
            chk("branch_count", branch_count_w, x.bc);
`endif
        end
    end

    initial begin
        idle();
        reset = 1'b1;
        tick(); tick();
        // single thread sequential fetch
        idle(); start(2'd0, 9'h010); tick();
        idle(); repeat (4) tick();
        // two threads alternate
        idle(); reset = 1'b1; tick();
        idle(); start(2'd0, 9'h000); tick();
        idle(); start(2'd2, 9'h100); tick();
        idle(); repeat (5) tick();
        // beq taken, then bneq not taken with equal operands
        idle(); branch(2'd0, 9'h020, 9'h010, 64'd5, 64'd5, 1'b1, 1'b0); tick();
        idle(); branch(2'd0, 9'h020, 9'h010, 64'd5, 64'd5, 1'b0, 1'b1); tick();
        idle(); repeat (4) tick();
        // wrap-around target with same-cycle bypass
        idle(); reset = 1'b1; tick();
        idle(); start(2'd1, 9'h1F0); tick();
        idle(); branch(2'd1, 9'h1FF, 9'h002, 64'd7, 64'd7, 1'b1, 1'b0); tick();
        idle(); repeat (3) tick();
        // stall with a taken branch presented
        idle(); en = 1'b0; branch(2'd1, 9'h050, 9'h005, 64'd1, 64'd1, 1'b1, 1'b1); repeat (3) tick();
        idle(); start(2'd1, 9'h080); stop_valid = 1'b1; stop_id = 2'd1; tick();
        idle(); start(2'd3, 9'h0A0); stop_valid = 1'b1; stop_id = 2'd3; tick();
        // 4 taken, 3 not taken on a running thread
        idle(); start(2'd2, 9'h040); tick();
        for (int i = 0; i < 7; i++) begin
            idle();
            if (i < 4) branch(2'd2, 9'h040, 9'(i), 64'd9, 64'd9, 1'b1, 1'b0);
            else       branch(2'd2, 9'h040, 9'(i), 64'd9, 64'd9, 1'b0, 1'b1);
            tick();
        end
        idle(); tick();
        idle(); reset = 1'b1; tick();
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            idle();
            reset = ($urandom_range(0, 299) == 0);
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 1) == 1)
                branch(2'($urandom_range(0, 3)), 9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)),
                       64'($urandom_range(0, 2)), 64'($urandom_range(0, 2)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) start(2'($urandom_range(0, 3)), 9'($urandom_range(0, 511)));
            if ($urandom_range(0, 11) == 0) begin
                stop_valid = 1'b1;
                stop_id = 2'($urandom_range(0, 3));
            end
            tick();
        end
        idle(); tick();
        @(posedge clk); #2;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
